rdc_ctrl: RTL and testbench
===========================

RDC_CTRL -- requirements
Module: rdc_ctrl

Interface
REQ-001 The block SHALL have parameter N_CORES, default 4, number of monitored cores.
REQ-002 The block SHALL have parameter CORE_EVENTS, default 2, events per core; N_COUNTERS = N_CORES*CORE_EVENTS.
REQ-003 The block SHALL have parameter WEIGHTS_WIDTH, default 8, width of each weight.
REQ-004 The block SHALL have parameter COOLDOWN_WIDTH, default 16, width of the cooldown counter.
REQ-005 The block SHALL have parameter TRIP_CNT_WIDTH, default 16, width of the trip counter.
REQ-006 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port cfg_we_i, input, 1 bit, shadow-weight write strobe.
REQ-009 The block SHALL have port cfg_addr_i, input, $clog2(N_COUNTERS) bits, weight index core*CORE_EVENTS+event.
REQ-010 The block SHALL have port cfg_wdata_i, input, WEIGHTS_WIDTH bits, weight write data.
REQ-011 The block SHALL have ports start_i and stop_i, inputs, 1 bit each, single-cycle command pulses.
REQ-012 The block SHALL have port ack_i, input, 1 bit, software acknowledge.
REQ-013 The block SHALL have port cooldown_i, input, COOLDOWN_WIDTH bits, auto-rearm delay; 0 disables auto-rearm.
REQ-014 The block SHALL have ports rdc_irq_i (1 bit) and rdc_vector_i (N_COUNTERS bits), inputs, the monitor's interrupt and flattened per-event vector.
REQ-015 The block SHALL have outputs rdc_enable_o and rdc_rstn_o (1 bit each), enable and active-low reset driven to the monitor.
REQ-016 The block SHALL have output weights_o, N_COUNTERS*WEIGHTS_WIDTH bits, active weights; index i at bits [i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH].
REQ-017 The block SHALL have outputs state_o (3 bits), status_vector_o (N_COUNTERS bits), trip_count_o (TRIP_CNT_WIDTH bits) and irq_o (1 bit).

Function
REQ-018 The block SHALL implement FSM states IDLE, CLEAR, ARMED, TRIPPED, COOLDOWN, exposed on state_o.
REQ-019 IDLE: on start_i without stop_i, go to CLEAR; if both are asserted, stop_i SHALL win and the FSM stays in IDLE.
REQ-020 CLEAR lasts exactly one cycle: rdc_rstn_o=0; active weights <= shadow weights; next state ARMED.
REQ-021 rdc_enable_o SHALL be 1 only in ARMED; rdc_rstn_o SHALL be 0 only in CLEAR or while rst_i=1.
REQ-022 Latency: start_i at cycle t gives CLEAR at t+1 and rdc_enable_o=1 at t+2.
REQ-023 ARMED: on rdc_irq_i=1 at cycle t, the FSM SHALL enter TRIPPED at t+1; status_vector_o |= rdc_vector_i; trip_count_o increments, saturating at all-ones.
REQ-024 ARMED: stop_i SHALL go to IDLE; with a simultaneous rdc_irq_i, stop_i wins the transition but the capture and count of REQ-023 still occur.
REQ-025 TRIPPED with cooldown_i=0: hold until ack_i, then go to CLEAR.
REQ-026 TRIPPED with cooldown_i!=0: load the counter with cooldown_i and go to COOLDOWN.
REQ-027 COOLDOWN: decrement each cycle; when the counter equals 1, go to CLEAR, so COOLDOWN lasts exactly cooldown_i cycles.
REQ-028 stop_i SHALL force IDLE from any state except CLEAR, with priority over ack_i and cooldown expiry; in CLEAR, stop_i is ignored.
REQ-029 cfg_we_i SHALL write the shadow weight in any state; active weights change only in CLEAR; a write during CLEAR lands in shadow and commits at the next CLEAR.
REQ-030 cfg_addr_i >= N_COUNTERS SHALL be ignored.
REQ-031 ack_i SHALL clear status_vector_o in any state; a same-cycle capture SHALL win, so newly captured bits are set.
REQ-032 irq_o SHALL equal |status_vector_o (level output).
REQ-033 trip_count_o SHALL be cleared only by reset.

Reset
REQ-034 With rst_i=1 at a clock edge: state=IDLE, shadow/active weights=0, status_vector_o=0, trip_count_o=0, cooldown counter=0.
REQ-035 Reset mid-operation from any state SHALL drive rdc_enable_o=0 and rdc_rstn_o=0 in the same cycle.

Structure
REQ-036 A shared package rdc_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 Shadow and active weight storage SHALL be in sub-module rdc_weight_bank, ports: write, commit, flattened read.
REQ-038 rdc_enable_o, rdc_rstn_o and irq_o SHALL be decoded from registered state only, with no combinational path from rdc_irq_i.

Verification
REQ-039 Write weight 5 to index 3, then start_i -> CLEAR at t+1; weights_o[31:24]=5 and rdc_enable_o=1 at t+2.
REQ-040 ARMED, rdc_irq_i=1 with rdc_vector_i=8'h04, cooldown_i=0 -> TRIPPED next cycle, status=8'h04, trip_count=1, irq_o=1; ack_i -> CLEAR then ARMED, status=0.
REQ-041 Trip with cooldown_i=3 -> exactly 3 COOLDOWN cycles, then CLEAR, then ARMED; rdc_enable_o=0 throughout.
REQ-042 ARMED, same-cycle stop_i and rdc_irq_i -> IDLE, trip_count incremented, status captured.
REQ-043 Force trip_count to all-ones, trip again -> value unchanged; rst_i mid-COOLDOWN -> IDLE and all registers 0 next cycle.
REQ-044 Write to index 7 during CLEAR -> active weight unchanged until the following CLEAR; cfg_addr_i=8 -> no register changes.

Source files
------------

// File: rtl/rdc_pkg.sv
// Shared definitions for the RDC monitor controller: FSM state encoding
// and default parameter values.
package rdc_pkg;

  localparam int N_CORES_DEF        = 4;
  localparam int CORE_EVENTS_DEF    = 2;
  localparam int WEIGHTS_WIDTH_DEF  = 8;
  localparam int COOLDOWN_WIDTH_DEF = 16;
  localparam int TRIP_CNT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_ARMED    = 3'd2,
    ST_TRIPPED  = 3'd3,
    ST_COOLDOWN = 3'd4
  } rdc_state_e;

endpackage

// File: rtl/rdc_weight_bank.sv
// Shadow/active weight storage. Software writes the shadow copy at any
// time; the active copy seen by the monitor only changes on commit.
module rdc_weight_bank #(
  parameter int N_ENTRIES = 8,
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wr_en_i,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         commit_i,
  output logic [N_ENTRIES*WIDTH-1:0]   weights_o
);

  logic [N_ENTRIES-1:0][WIDTH-1:0] shadow_q;
  logic [N_ENTRIES-1:0][WIDTH-1:0] active_q;

  // Commit copies the pre-write shadow, so a write in the commit cycle waits
  // for the next commit. Addresses past the last entry match no slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (commit_i) active_q <= shadow_q;
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (wr_en_i && (int'(wr_addr_i) == i)) shadow_q[i] <= wr_data_i;
      end
    end
  end

  assign weights_o = active_q;

endmodule

// File: rtl/rdc_ctrl.sv
// Controller for a resource-demand monitor: arms it, captures trips,
// counts them, and re-arms on software ack or after a cooldown delay.
module rdc_ctrl import rdc_pkg::*; #(
  parameter int N_CORES        = N_CORES_DEF,
  parameter int CORE_EVENTS    = CORE_EVENTS_DEF,
  parameter int WEIGHTS_WIDTH  = WEIGHTS_WIDTH_DEF,
  parameter int COOLDOWN_WIDTH = COOLDOWN_WIDTH_DEF,
  parameter int TRIP_CNT_WIDTH = TRIP_CNT_WIDTH_DEF
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            cfg_we_i,
  input  logic [$clog2(N_CORES*CORE_EVENTS)-1:0]          cfg_addr_i,
  input  logic [WEIGHTS_WIDTH-1:0]                        cfg_wdata_i,
  input  logic                                            start_i,
  input  logic                                            stop_i,
  input  logic                                            ack_i,
  input  logic [COOLDOWN_WIDTH-1:0]                       cooldown_i,
  input  logic                                            rdc_irq_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]                  rdc_vector_i,
  output logic                                            rdc_enable_o,
  output logic                                            rdc_rstn_o,
  output logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0]    weights_o,
  output logic [2:0]                                      state_o,
  output logic [N_CORES*CORE_EVENTS-1:0]                  status_vector_o,
  output logic [TRIP_CNT_WIDTH-1:0]                       trip_count_o,
  output logic                                            irq_o
);

  localparam int N_COUNTERS = N_CORES * CORE_EVENTS;
  localparam int ADDR_W     = $clog2(N_COUNTERS);
  localparam logic [TRIP_CNT_WIDTH-1:0] TRIP_ONE = {{(TRIP_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COOLDOWN_WIDTH-1:0] CD_ONE   = {{(COOLDOWN_WIDTH-1){1'b0}}, 1'b1};

  rdc_state_e                state_q;
  logic [COOLDOWN_WIDTH-1:0] cd_q;
  logic [N_COUNTERS-1:0]     status_q, status_d;
  logic [TRIP_CNT_WIDTH-1:0] trip_q, trip_d;
  logic                      capture;

  // Trip capture and ack: ack clears first, then a same-cycle capture ORs in
  // so new bits survive. The trip counter saturates instead of wrapping.
  always_comb begin
    capture  = (state_q == ST_ARMED) && rdc_irq_i;
    status_d = status_q;
    trip_d   = trip_q;
    if (ack_i) status_d = '0;
    if (capture) begin
      status_d = status_d | rdc_vector_i;
      if (trip_q != '1) trip_d = trip_q + TRIP_ONE;
    end
  end

  // Control FSM plus status/trip/cooldown registers. stop_i overrides every
  // transition except the single CLEAR cycle, which always proceeds to ARMED.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cd_q     <= '0;
      status_q <= '0;
      trip_q   <= '0;
    end else begin
      status_q <= status_d;
      trip_q   <= trip_d;
      unique case (state_q)
        ST_IDLE:    if (start_i && !stop_i) state_q <= ST_CLEAR;
        ST_CLEAR:   state_q <= ST_ARMED;
        ST_ARMED: begin
          if (stop_i)         state_q <= ST_IDLE;
          else if (rdc_irq_i) state_q <= ST_TRIPPED;
        end
        ST_TRIPPED: begin
          if (stop_i) state_q <= ST_IDLE;
          else if (cooldown_i != '0) begin
            cd_q    <= cooldown_i;
            state_q <= ST_COOLDOWN;
          end else if (ack_i) state_q <= ST_CLEAR;
        end
        ST_COOLDOWN: begin
          if (stop_i) begin
            cd_q    <= '0;
            state_q <= ST_IDLE;
          end else begin
            cd_q <= cd_q - CD_ONE;
            if (cd_q == CD_ONE) state_q <= ST_CLEAR;
          end
        end
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  rdc_weight_bank #(
    .N_ENTRIES (N_COUNTERS),
    .WIDTH     (WEIGHTS_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (cfg_we_i),
    .wr_addr_i (cfg_addr_i),
    .wr_data_i (cfg_wdata_i),
    .commit_i  (state_q == ST_CLEAR),
    .weights_o (weights_o)
  );

  // Monitor controls come from registered state only; rst_i gates them so
  // the monitor is held off in the same cycle reset is asserted.
  assign rdc_enable_o    = (state_q == ST_ARMED) && !rst_i;
  assign rdc_rstn_o      = (state_q != ST_CLEAR) && !rst_i;
  assign state_o         = state_q;
  assign status_vector_o = status_q;
  assign trip_count_o    = trip_q;
  assign irq_o           = |status_q;

endmodule

// File: tb/tb_rdc_ctrl.sv
// Self-checking bench for rdc_ctrl: directed scenarios plus randomized
// traffic against a behavioural model of the controller.
module tb_rdc_ctrl;
  import rdc_pkg::*;

  localparam int NC  = 3;
  localparam int CE  = 2;
  localparam int NCT = NC * CE;
  localparam int WW  = 8;
  localparam int CDW = 16;
  localparam int TW  = 3;
  localparam int AW  = $clog2(NCT);
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1, we = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0, irq = 1'b0;
  logic [AW-1:0]  addr = '0;
  logic [WW-1:0]  wdata = '0;
  logic [CDW-1:0] cd = '0;
  logic [NCT-1:0] vec = '0;

  logic              enable_o, rstn_o, irq_o;
  logic [NCT*WW-1:0] weights_o;
  logic [2:0]        state_o;
  logic [NCT-1:0]    status_o;
  logic [TW-1:0]     trip_o;

  rdc_ctrl #(.N_CORES(NC), .CORE_EVENTS(CE), .WEIGHTS_WIDTH(WW),
             .COOLDOWN_WIDTH(CDW), .TRIP_CNT_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(we), .cfg_addr_i(addr), .cfg_wdata_i(wdata),
    .start_i(start), .stop_i(stop), .ack_i(ack), .cooldown_i(cd),
    .rdc_irq_i(irq), .rdc_vector_i(vec),
    .rdc_enable_o(enable_o), .rdc_rstn_o(rstn_o), .weights_o(weights_o),
    .state_o(state_o), .status_vector_o(status_o), .trip_count_o(trip_o), .irq_o(irq_o));

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase name, cooldown cycles left, sticky status,
  // saturating trip tally, shadow and active weight arrays.
  rdc_state_e     m_st = ST_IDLE;
  int             m_cd_left = 0;
  logic [NCT-1:0] m_status = '0;
  int             m_trip = 0;
  logic [WW-1:0]  m_shadow [NCT];
  logic [WW-1:0]  m_active [NCT];

  task automatic model_update();
    bool_dummy: begin end
    if (rst) begin
      m_st = ST_IDLE; m_cd_left = 0; m_status = '0; m_trip = 0;
      for (int i = 0; i < NCT; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    end else begin
      if (m_st == ST_CLEAR)
        for (int i = 0; i < NCT; i++) m_active[i] = m_shadow[i];
      if (we && int'(addr) < NCT) m_shadow[addr] = wdata;
      if (m_st == ST_ARMED && irq) begin
        m_status = (ack ? '0 : m_status) | vec;
        if (m_trip < TMAX) m_trip = m_trip + 1;
      end else if (ack) m_status = '0;
      case (m_st)
        ST_IDLE:    if (start && !stop) m_st = ST_CLEAR;
        ST_CLEAR:   m_st = ST_ARMED;
        ST_ARMED:   if (stop) m_st = ST_IDLE; else if (irq) m_st = ST_TRIPPED;
        ST_TRIPPED: if (stop) m_st = ST_IDLE;
                    else if (cd != 0) begin m_cd_left = int'(cd); m_st = ST_COOLDOWN; end
                    else if (ack) m_st = ST_CLEAR;
        default: begin
          m_cd_left = m_cd_left - 1;
          if (stop) m_st = ST_IDLE;
          else if (m_cd_left == 0) m_st = ST_CLEAR;
        end
      endcase
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    we = 0; start = 0; stop = 0; ack = 0; irq = 0; vec = '0; cd = '0; addr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1; quiet(); #1;
    checks++; if (rstn_o !== 1'b0) begin errors++; $display("FAIL rst_rstn act=%b exp=0", rstn_o); end
    tick(); tick();
    rst = 0; #1;
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rst_state act=%0d exp=%0d", state_o, ST_IDLE); end
    checks++; if (status_o !== '0 || trip_o !== '0 || weights_o !== '0) begin errors++;
      $display("FAIL rst_regs status=%h trip=%0d weights=%h exp=0", status_o, trip_o, weights_o); end
    checks++; if (enable_o !== 1'b0 || rstn_o !== 1'b1 || irq_o !== 1'b0) begin errors++;
      $display("FAIL rst_outs en=%b rstn=%b irq=%b exp=0/1/0", enable_o, rstn_o, irq_o); end
  endtask

  task automatic test_start();
    we = 1; addr = 3; wdata = 8'd5; tick(); we = 0;
    start = 1; tick(); start = 0;
    checks++; if (state_o !== ST_CLEAR || rstn_o !== 1'b0 || enable_o !== 1'b0) begin errors++;
      $display("FAIL start_clear state=%0d rstn=%b en=%b exp=%0d/0/0", state_o, rstn_o, enable_o, ST_CLEAR); end
    tick();
    checks++; if (state_o !== ST_ARMED || enable_o !== 1'b1) begin errors++;
      $display("FAIL start_armed state=%0d en=%b exp=%0d/1", state_o, enable_o, ST_ARMED); end
    checks++; if (weights_o[31:24] !== 8'd5) begin errors++; $display("FAIL start_weight act=%0d exp=5", weights_o[31:24]); end
  endtask

  task automatic test_trip_ack();
    irq = 1; vec = 6'h04; cd = 0; tick(); irq = 0; vec = '0;
    checks++; if (state_o !== ST_TRIPPED || status_o !== 6'h04 || trip_o !== 3'd1 || irq_o !== 1'b1) begin errors++;
      $display("FAIL trip state=%0d status=%h trip=%0d irq=%b exp=%0d/04/1/1", state_o, status_o, trip_o, irq_o, ST_TRIPPED); end
    ack = 1; tick(); ack = 0;
    checks++; if (state_o !== ST_CLEAR || status_o !== '0 || irq_o !== 1'b0) begin errors++;
      $display("FAIL ack_clear state=%0d status=%h irq=%b exp=%0d/00/0", state_o, status_o, irq_o, ST_CLEAR); end
    tick();
    checks++; if (state_o !== ST_ARMED) begin errors++; $display("FAIL ack_rearm act=%0d exp=%0d", state_o, ST_ARMED); end
  endtask

  task automatic test_cooldown();
    int n = 0, guard = 0;
    irq = 1; vec = 6'h02; cd = 3; tick(); irq = 0; vec = '0;
    checks++; if (state_o !== ST_TRIPPED) begin errors++; $display("FAIL cd_trip act=%0d exp=%0d", state_o, ST_TRIPPED); end
    tick();
    while (state_o === ST_COOLDOWN && guard < 20) begin
      n++; guard++;
      checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL cd_enable act=%b exp=0", enable_o); end
      tick();
    end
    cd = 0;
    checks++; if (n !== 3) begin errors++; $display("FAIL cd_cycles act=%0d exp=3", n); end
    checks++; if (state_o !== ST_CLEAR || enable_o !== 1'b0) begin errors++;
      $display("FAIL cd_clear state=%0d en=%b exp=%0d/0", state_o, enable_o, ST_CLEAR); end
    tick();
    checks++; if (state_o !== ST_ARMED) begin errors++; $display("FAIL cd_rearm act=%0d exp=%0d", state_o, ST_ARMED); end
  endtask

  task automatic test_stop_irq();
    stop = 1; irq = 1; vec = 6'h21; tick(); stop = 0; irq = 0; vec = '0;
    checks++; if (state_o !== ST_IDLE || trip_o !== 3'd3 || status_o !== 6'h23) begin errors++;
      $display("FAIL stop_irq state=%0d trip=%0d status=%h exp=%0d/3/23", state_o, trip_o, status_o, ST_IDLE); end
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL start_stop act=%0d exp=%0d", state_o, ST_IDLE); end
  endtask

  task automatic test_saturate_reset();
    start = 1; tick(); start = 0; tick();
    for (int k = 0; k < 5; k++) begin
      irq = 1; vec = 6'h01; tick(); irq = 0; vec = '0;
      ack = 1; tick(); ack = 0; tick();
      if (k == 3) begin
        checks++; if (trip_o !== 3'd7) begin errors++; $display("FAIL trip_max act=%0d exp=7", trip_o); end
      end
    end
    checks++; if (trip_o !== 3'd7 || state_o !== ST_ARMED) begin errors++;
      $display("FAIL trip_sat trip=%0d state=%0d exp=7/%0d", trip_o, state_o, ST_ARMED); end
    cd = 5; irq = 1; tick(); irq = 0; tick(); tick();
    checks++; if (state_o !== ST_COOLDOWN) begin errors++; $display("FAIL mid_cd act=%0d exp=%0d", state_o, ST_COOLDOWN); end
    rst = 1; #1;
    checks++; if (enable_o !== 1'b0 || rstn_o !== 1'b0) begin errors++;
      $display("FAIL rst_now en=%b rstn=%b exp=0/0", enable_o, rstn_o); end
    tick(); rst = 0; cd = 0; #1;
    checks++; if (state_o !== ST_IDLE || trip_o !== '0 || status_o !== '0 || weights_o !== '0 || irq_o !== 1'b0) begin errors++;
      $display("FAIL rst_mid state=%0d trip=%0d status=%h w=%h irq=%b exp=all0", state_o, trip_o, status_o, weights_o, irq_o); end
  endtask

  task automatic test_clear_write();
    we = 1; addr = 5; wdata = 8'hA1; tick(); we = 0;
    start = 1; tick(); start = 0;
    we = 1; addr = 5; wdata = 8'hB2; tick(); we = 0;
    checks++; if (weights_o[47:40] !== 8'hA1) begin errors++; $display("FAIL clr_write act=%h exp=a1", weights_o[47:40]); end
    we = 1; addr = 6; wdata = 8'hFF; tick(); addr = 7; tick(); we = 0;
    checks++; if (weights_o !== {8'hA1, 40'h0} || state_o !== ST_ARMED) begin errors++;
      $display("FAIL oor_write w=%h state=%0d exp=a1..0/%0d", weights_o, state_o, ST_ARMED); end
    stop = 1; tick(); stop = 0; start = 1; tick(); start = 0; tick();
    checks++; if (weights_o !== {8'hB2, 40'h0}) begin errors++; $display("FAIL next_commit act=%h exp=b2..0", weights_o); end
  endtask

  task automatic test_random();
    logic [NCT*WW-1:0] exp_w;
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      ack   = ($urandom_range(0, 5) == 0);
      irq   = ($urandom_range(0, 3) == 0);
      vec   = NCT'($urandom);
      we    = ($urandom_range(0, 2) == 0);
      addr  = AW'($urandom);
      wdata = WW'($urandom);
      cd    = ($urandom_range(0, 1) == 0) ? '0 : CDW'($urandom_range(1, 4));
      #1;
      for (int i = 0; i < NCT; i++) exp_w[i*WW +: WW] = m_active[i];
      checks++;
      if (state_o !== m_st || status_o !== m_status || trip_o !== m_trip[TW-1:0] || weights_o !== exp_w ||
          enable_o !== (m_st == ST_ARMED && !rst) || rstn_o !== (m_st != ST_CLEAR && !rst) ||
          irq_o !== (|m_status)) begin
        errors++;
        $display("FAIL rand c=%0d state=%0d/%0d status=%h/%h trip=%0d/%0d w=%h/%h en=%b rstn=%b irq=%b",
                 c, state_o, m_st, status_o, m_status, trip_o, m_trip, weights_o, exp_w, enable_o, rstn_o, irq_o);
      end
      tick();
    end
    rst = 0; quiet();
  endtask

  initial begin
    for (int i = 0; i < NCT; i++) begin m_shadow[i] = '0; m_active[i] = '0; end
    test_reset();
    test_start();
    test_trip_ack();
    test_cooldown();
    test_stop_irq();
    test_saturate_reset();
    test_clear_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
